reg_scoreboard: RTL
===================

# reg_scoreboard

Hazard scoreboard and write-port arbiter for the 32×32 register file. Tracks destinations of in-flight long-latency (mul/div) operations. Stalls issue on RAW/WAW hazards against them. Shares the register file's single write port between the in-order pipeline writeback and the MDU result stream. Sits between decode/issue, the writeback stage, the MDU and the register file's write port.

## Interface
- MAX_LONG, 2: maximum outstanding long-latency ops (≥1)
- STARVE_LIMIT, 4: cycles a buffered MDU result may wait before pipeline writeback is held (≥1; used only with the guard enabled)

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- issue_valid  in  1  decode presents an instruction this cycle
- issue_re1 / issue_re2  in  1  source operand 1/2 is used
- issue_raddr1 / issue_raddr2  in  5  source register addresses
- issue_we  in  1  instruction writes a register
- issue_waddr  in  5  destination register
- issue_long  in  1  destination is produced by the MDU
- stall  out  1  issue must hold; instruction not accepted
- wb_valid  in  1  pipeline writeback request (cannot be back-pressured except via wb_hold)
- wb_waddr  in  5 / wb_wdata  in  32  pipeline writeback address/data
- wb_hold  out  1  writeback not performed this cycle; the pipeline re-presents the same request next cycle
- mdu_valid  in  1 / mdu_ready  out  1  MDU result handshake
- mdu_waddr  in  5 / mdu_wdata  in  32  MDU result address/data
- rf_we  out  1 / rf_waddr  out  5 / rf_wdata  out  32  register file write port

## Operation
- State: pending[31:0], outstanding counter (clog2(MAX_LONG+1) bits), one-entry MDU buffer (valid, addr, data), starve counter.
- Hazard detection. stall = issue_valid & (raw | waw | full).
  - raw: (issue_re1 & pending[issue_raddr1]) | (issue_re2 & pending[issue_raddr2]).
  - waw: issue_we & pending[issue_waddr].
  - full: issue_we & issue_long & outstanding==MAX_LONG.
  - Register 0 is never pending.
- Accept a long op when issue_valid & !stall & issue_we & issue_long. On accept: set pending[issue_waddr] (skipped if 0) and increment outstanding.
- MDU capture: mdu_ready = !buf_valid. On mdu_valid & mdu_ready, load the buffer.
- Write arbitration:
  - grant_mdu = buf_valid & (!wb_valid | wb_hold).
  - With grant_mdu, the port is driven from the buffer.
  - Otherwise the port is driven from the pipeline: rf_we = wb_valid & (wb_waddr != 0).
- On grant_mdu: clear buf_valid, clear pending[buf_addr], decrement outstanding.
- Simultaneous accept and grant in one cycle: the counter is unchanged. The set/clear pair targets different registers, because WAW blocks the same register.
- Stall is computed from registered pending only. A clear becomes visible the cycle after the grant.
- MDU results with address 0 are accepted and retired; rf_we stays low.

## Timing
- Reset values:
  - State: pending=0, outstanding=0, buf_valid=0, starve=0.
  - Outputs: mdu_ready=1, wb_hold=0, stall=0 absent hazards.
  - rf_* follow the pipeline path.
- Reset mid-operation discards the buffered result and all pending bits immediately.
- MDU latency, from mdu_valid&ready in cycle N:
  - buffer valid in N+1.
  - Earliest register write at the end of N+1.
  - Dependent issue unstalls in N+2.
- A new MDU result is not accepted in the same cycle the buffer drains. Next accept is at N+2.
- Pipeline writeback has zero added latency except when wb_hold is asserted.

## Configuration
- SB_STARVE_GUARD_EN defined:
  - starve increments each cycle buf_valid & wb_valid & !grant_mdu.
  - It resets to 0 on grant_mdu or !buf_valid.
  - At starve==STARVE_LIMIT, wb_hold=1 for exactly one cycle and the MDU is granted.
- Not defined: wb_hold is tied 0, no starve counter exists, and the MDU drains only in cycles with wb_valid=0.

## Structure
- Shared package holds:
  - REG_ADDR_W=5, REG_NUM=32, DATA_W=32.
  - The register-0 constant.
- Sub-module sb_wb_arbiter contains:
  - MDU buffer, starve counter, write mux.
  - Outputs: grant_mdu and retire address.
- The top contains the pending vector, the outstanding counter and the hazard logic.

## Test plan
- Issue long op to r5, then issue read of r5 next cycle -> stall=1 until the cycle after the MDU write of r5. The dependent instruction is then accepted.
- Two long ops (r3, r4) with MAX_LONG=2, then a third long op -> stall=1 (full). Retire r3 -> third issue accepted one cycle later.
- Issue long to r7 pending, then issue short write to r7 -> stall=1 (WAW). Non-dependent read of r8 -> stall=0.
- wb_valid held high continuously with MDU result 0xDEADBEEF→r9 buffered, STARVE_LIMIT=4 (guard on):
  - wb_hold=1 on the 5th cycle.
  - rf_waddr=9, rf_wdata=0xDEADBEEF in that cycle.
  - Pipeline write follows next cycle.
  - With the guard off, there is no write until wb_valid drops.
- MDU result to r0 and pipeline write to r0 -> rf_we=0. The MDU entry is still retired and outstanding is decremented.
- Assert rst with buffer valid and pending={r2,r6} -> mdu_ready=1, pending=0, reads of r2 immediately unstalled.

Source files
------------

// File: rtl/reg_scoreboard_pkg.sv
// reg_scoreboard_pkg: shared register-file widths and helpers for the hazard scoreboard
package reg_scoreboard_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int REG_NUM = 32;
    localparam int DATA_W = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;
    function automatic logic [REG_NUM-1:0] reg_mask(input logic [REG_ADDR_W-1:0] a);
        reg_mask = (a == REG_ZERO) ? '0 : REG_NUM'(1) << a;
    endfunction
endpackage

// File: rtl/reg_scoreboard_wb_arbiter.sv
// sb_wb_arbiter: one-entry MDU result buffer and register-file write-port mux (starvation guard under SB_STARVE_GUARD_EN)
module sb_wb_arbiter
    import reg_scoreboard_pkg::*;
`ifdef SB_STARVE_GUARD_EN
#(
    parameter int STARVE_LIMIT = 4
)
`endif
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_waddr,
    input  logic [DATA_W-1:0]     wb_wdata,
    output logic                  wb_hold,
    input  logic                  mdu_valid,
    output logic                  mdu_ready,
    input  logic [REG_ADDR_W-1:0] mdu_waddr,
    input  logic [DATA_W-1:0]     mdu_wdata,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0]     rf_wdata,
    output logic                  grant_mdu,
    output logic [REG_ADDR_W-1:0] retire_addr
);
    logic                  buf_valid;
    logic [REG_ADDR_W-1:0] buf_addr;
    logic [DATA_W-1:0]     buf_data;

    assign mdu_ready = !buf_valid;
    assign grant_mdu = buf_valid & (!wb_valid | wb_hold);
    assign retire_addr = buf_addr;

    // Capture an MDU result into the empty buffer; release it when the port is granted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_valid <= 1'b0;
            buf_addr <= '0;
            buf_data <= '0;
        end else if (mdu_valid && mdu_ready) begin
            buf_valid <= 1'b1;
            buf_addr <= mdu_waddr;
            buf_data <= mdu_wdata;
        end else if (grant_mdu) begin
            buf_valid <= 1'b0;
        end
    end

`ifdef SB_STARVE_GUARD_EN
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    logic [STARVE_W-1:0] starve;

    assign wb_hold = buf_valid & wb_valid & (starve == STARVE_W'(STARVE_LIMIT));

    // Count cycles the buffered result loses the port to pipeline writeback
    always_ff @(posedge clk or posedge rst) begin
        if (rst) starve <= '0;
        else if (!buf_valid || grant_mdu) starve <= '0;
        else if (wb_valid) starve <= starve + STARVE_W'(1);
    end
`else
    assign wb_hold = 1'b0;
`endif

    // Drive the write port from the buffer when granted, otherwise from the pipeline; r0 never written
    always_comb begin
        rf_we = grant_mdu ? (buf_addr != REG_ZERO) : (wb_valid && wb_waddr != REG_ZERO);
        rf_waddr = grant_mdu ? buf_addr : wb_waddr;
        rf_wdata = grant_mdu ? buf_data : wb_wdata;
    end
endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: RAW/WAW/capacity hazard scoreboard for long-latency ops plus write-port arbitration (SB_STARVE_GUARD_EN enables the starvation guard)
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int MAX_LONG = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    input  logic                  issue_re1,
    input  logic                  issue_re2,
    input  logic [REG_ADDR_W-1:0] issue_raddr1,
    input  logic [REG_ADDR_W-1:0] issue_raddr2,
    input  logic                  issue_we,
    input  logic [REG_ADDR_W-1:0] issue_waddr,
    input  logic                  issue_long,
    output logic                  stall,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_waddr,
    input  logic [DATA_W-1:0]     wb_wdata,
    output logic                  wb_hold,
    input  logic                  mdu_valid,
    output logic                  mdu_ready,
    input  logic [REG_ADDR_W-1:0] mdu_waddr,
    input  logic [DATA_W-1:0]     mdu_wdata,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0]     rf_wdata
);
    localparam int CNT_W = $clog2(MAX_LONG + 1);

    logic [REG_NUM-1:0]    pending;
    logic [CNT_W-1:0]      outstanding;
    logic                  raw, waw, full, accept, dec, grant_mdu;
    logic [REG_ADDR_W-1:0] retire_addr;

    assign raw = (issue_re1 & pending[issue_raddr1]) | (issue_re2 & pending[issue_raddr2]);
    assign waw = issue_we & pending[issue_waddr];
    assign full = issue_we & issue_long & (outstanding == CNT_W'(MAX_LONG));
    assign stall = issue_valid & (raw | waw | full);
    assign accept = issue_valid & !stall & issue_we & issue_long;
    assign dec = grant_mdu & (accept | (outstanding != '0));

    // Track in-flight destinations: set on long-op accept, clear on MDU retire
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
            outstanding <= '0;
        end else begin
            pending <= (pending | (accept ? reg_mask(issue_waddr) : '0)) & ~(grant_mdu ? reg_mask(retire_addr) : '0);
            outstanding <= outstanding + CNT_W'(accept) - CNT_W'(dec);
        end
    end

    sb_wb_arbiter
`ifdef SB_STARVE_GUARD_EN
        #(.STARVE_LIMIT(STARVE_LIMIT))
`endif
        u_arb (
            .clk(clk),
            .rst(rst),
            .wb_valid(wb_valid),
            .wb_waddr(wb_waddr),
            .wb_wdata(wb_wdata),
            .wb_hold(wb_hold),
            .mdu_valid(mdu_valid),
            .mdu_ready(mdu_ready),
            .mdu_waddr(mdu_waddr),
            .mdu_wdata(mdu_wdata),
            .rf_we(rf_we),
            .rf_waddr(rf_waddr),
            .rf_wdata(rf_wdata),
            .grant_mdu(grant_mdu),
            .retire_addr(retire_addr)
        );
endmodule
